// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm beeper: FSM state encoding and counter sizing.
// Pure declarations only, so it has no latency or backpressure of its own.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP  = 2'd1,
    GAP   = 2'd2,
    PAUSE = 2'd3
  } alarm_state_t;

  localparam int MS_PER_S = 1000;

  // Bits needed by a counter that runs 0..max_count-1, never narrower than 1.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave divider: output starts high on the first enabled cycle and toggles every HALF_PERIOD cycles.
// Zero-latency gating by enable (output low whenever disabled); no backpressure, free-running while enabled.
module tone_gen
  import alarm_pkg::*;
#(
  parameter int HALF_PERIOD = 5
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic wave
);

  localparam int CW = cnt_width(HALF_PERIOD);

  logic [CW-1:0] cnt;
  logic          phase;

  // While disabled the divider is parked at the start of a high half-period,
  // so every enable begins with a full-length high phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!enable) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CW'(HALF_PERIOD - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + 1'b1;
    end
  end

  assign wave = enable & phase;

endmodule

// File: rtl/alarm_beeper.sv
// Alarm pattern sequencer (BEEP/GAP groups; ALARM_REPEAT_EN adds PAUSE and repeats groups until stop).
// One-cycle response to start/stop; outputs decode the state register directly, no backpressure.
module alarm_beeper
  import alarm_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int BEEP_MS    = 200,
  parameter int GAP_MS     = 100,
  parameter int BEEP_COUNT = 3,
  parameter int REPEAT_MS  = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic stop,
  output logic buzzer,
  output logic beep_on,
  output logic active
);

  localparam int TICKS_PER_MS = CLK_HZ / MS_PER_S;
  localparam int TONE_HALF    = CLK_HZ / (2 * TONE_HZ);
`ifdef ALARM_REPEAT_EN
  localparam int MS_MAX = max2(max2(BEEP_MS, GAP_MS), REPEAT_MS);
`else
  // REPEAT_MS has no effect without repeating groups; the zero term only keeps it referenced.
  localparam int MS_MAX = max2(BEEP_MS, GAP_MS) + 0 * REPEAT_MS;
`endif
  localparam int PW = cnt_width(TICKS_PER_MS);
  localparam int MW = cnt_width(MS_MAX);
  localparam int IW = cnt_width(BEEP_COUNT);

  alarm_state_t  state, state_nx;
  logic [PW-1:0] presc;
  logic [MW-1:0] ms_cnt;
  logic [IW-1:0] beep_idx, beep_idx_nx;
  logic          tick;
  logic          ms_last;
  logic          expire;

  assign tick = (presc == PW'(TICKS_PER_MS - 1));

  always_comb begin
    ms_last = 1'b0;
    case (state)
      BEEP:  ms_last = (ms_cnt == MW'(BEEP_MS - 1));
      GAP:   ms_last = (ms_cnt == MW'(GAP_MS - 1));
`ifdef ALARM_REPEAT_EN
      PAUSE: ms_last = (ms_cnt == MW'(REPEAT_MS - 1));
`endif
      default: ms_last = 1'b0;
    endcase
  end

  // Last cycle of the state's final millisecond.
  assign expire = tick & ms_last;

  always_comb begin
    state_nx    = state;
    beep_idx_nx = beep_idx;
    if (stop) begin
      state_nx    = IDLE;
      beep_idx_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx    = BEEP;
            beep_idx_nx = '0;
          end
        end
        BEEP: begin
          if (expire) begin
            if (beep_idx < IW'(BEEP_COUNT - 1)) begin
              state_nx = GAP;
            end else begin
`ifdef ALARM_REPEAT_EN
              state_nx = PAUSE;
`else
              state_nx = IDLE;
`endif
              beep_idx_nx = '0;
            end
          end
        end
        GAP: begin
          if (expire) begin
            state_nx    = BEEP;
            beep_idx_nx = beep_idx + 1'b1;
          end
        end
`ifdef ALARM_REPEAT_EN
        PAUSE: begin
          if (expire) begin
            state_nx    = BEEP;
            beep_idx_nx = '0;
          end
        end
`endif
        default: begin
          state_nx    = IDLE;
          beep_idx_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      beep_idx <= '0;
    end else begin
      state    <= state_nx;
      beep_idx <= beep_idx_nx;
    end
  end

  // Timebase restarts on every state entry and stays parked while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if ((state_nx != state) || (state == IDLE)) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else if (tick) begin
      presc  <= '0;
      ms_cnt <= ms_cnt + 1'b1;
    end else begin
      presc  <= presc + 1'b1;
    end
  end

  assign beep_on = (state == BEEP);
  assign active  = (state != IDLE);

  tone_gen #(
    .HALF_PERIOD(TONE_HALF)
  ) u_tone_gen (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (beep_on),
    .wave   (buzzer)
  );

endmodule

// File: tb/tb_alarm_beeper.sv
// Randomized scoreboard bench for alarm_beeper: a timeline model predicts {buzzer, beep_on, active} per cycle.
// Driver pushes predictions after each input change; an independent monitor pops and compares after each edge.
module tb_alarm_beeper;

  localparam int CLK_HZ     = 10_000;
  localparam int TONE_HZ    = 1000;
  localparam int BEEP_MS    = 2;
  localparam int GAP_MS     = 1;
  localparam int BEEP_COUNT = 2;
  localparam int REPEAT_MS  = 3;

  localparam int CYC_MS = CLK_HZ / 1000;
  localparam int B      = BEEP_MS * CYC_MS;
  localparam int GP     = GAP_MS * CYC_MS;
  localparam int R      = REPEAT_MS * CYC_MS;
  localparam int HALF   = CLK_HZ / (2 * TONE_HZ);
  localparam int G      = BEEP_COUNT * B + (BEEP_COUNT - 1) * GP;
  localparam int PERIOD = G + R;
`ifdef ALARM_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic buzzer, beep_on, active;

  always #5 clk = ~clk;

  alarm_beeper #(
    .CLK_HZ(CLK_HZ), .TONE_HZ(TONE_HZ), .BEEP_MS(BEEP_MS),
    .GAP_MS(GAP_MS), .BEEP_COUNT(BEEP_COUNT), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .buzzer(buzzer), .beep_on(beep_on), .active(active)
  );

  int checks = 0;
  int passed = 0;
  logic [2:0] exp_q[$];

  // Model: m_p counts cycles since the pattern started; outputs follow from where m_p falls in the timeline.
  bit m_act = 1'b0;
  int m_p = 0;

  function automatic logic [2:0] model_out();
    int pos, r;
    bit beep, buzz;
    if (!m_act) return 3'b000;
    pos  = REPEAT ? (m_p % PERIOD) : m_p;
    r    = pos % (B + GP);
    beep = (pos < G) && (r < B);
    buzz = beep && (((r / HALF) % 2) == 0);
    return {buzz, beep, 1'b1};
  endfunction

  function automatic void model_step(bit s, bit p);
    if (p) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (s) begin
        m_act = 1'b1;
        m_p   = 0;
      end
    end else begin
      m_p++;
      if (!REPEAT && m_p >= G) m_act = 1'b0;
    end
  endfunction

  task automatic check_direct(input string name, input logic [2:0] req);
    checks++;
    if ({buzzer, beep_on, active} === req) passed++;
    else $display("FAIL %s t=%0t actual=%b required=%b", name, $time, {buzzer, beep_on, active}, req);
  endtask

  task automatic drive(input bit s, input bit p);
    @(negedge clk);
    #1;
    start = s;
    stop  = p;
    model_step(s, p);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_direct("async_rst", 3'b000);
    m_act = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({buzzer, beep_on, active} === e) passed++;
        else $display("FAIL out t=%0t actual=%b required=%b", $time, {buzzer, beep_on, active}, e);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout t=%0t actual=running required=finished", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin : stimulus
    #1;
    check_direct("reset", 3'b000);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // Full pattern (and three repeated groups when repeat is built in)
    drive(1'b1, 1'b0);
    idle(260);
    drive(1'b0, 1'b1);
    idle(5);

    // Stop early in the first beep
    drive(1'b1, 1'b0);
    idle(6);
    drive(1'b0, 1'b1);
    idle(3);

    // Simultaneous start and stop while idle
    drive(1'b1, 1'b1);
    idle(3);

    // Start re-issued during the gap must not disturb timing
    drive(1'b1, 1'b0);
    idle(24);
    drive(1'b1, 1'b0);
    idle(40);
    drive(1'b0, 1'b1);
    idle(2);

    // Asynchronous reset mid-beep, then idle held until a new start
    drive(1'b1, 1'b0);
    idle(8);
    async_reset();
    idle(5);
    drive(1'b1, 1'b0);
    idle(10);
    drive(1'b0, 1'b1);
    idle(2);

    // Random start/stop traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    drive(1'b0, 1'b1);
    idle(2);

    repeat (4) @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain actual=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alarm_beeper.md
ALARM_BEEPER -- requirements
Module: alarm_beeper

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter TONE_HZ, default 2000, meaning buzzer square-wave frequency.
REQ-003 SHALL have parameter BEEP_MS, default 200, meaning tone-on duration per beep.
REQ-004 SHALL have parameter GAP_MS, default 100, meaning silence between beeps in a group.
REQ-005 SHALL have parameter BEEP_COUNT, default 3, meaning beeps per group (legal range 1..15).
REQ-006 SHALL have parameter REPEAT_MS, default 1000, meaning silence between groups (used only with ALARM_REPEAT_EN).
REQ-007 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  one-cycle request to begin the alarm pattern.
REQ-010 SHALL have port stop  input  1  one-cycle request to silence and return to idle.
REQ-011 SHALL have port buzzer  output  1  tone square wave to the piezo, low when silent.
REQ-012 SHALL have port beep_on  output  1  envelope, high for every BEEP-state cycle (LED mirror).
REQ-013 SHALL have port active  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, BEEP, GAP, PAUSE; PAUSE reachable only with ALARM_REPEAT_EN.
REQ-015 SHALL derive a 1 ms tick from a prescaler counting 0..CLK_HZ/1000-1, cleared on every state entry.
REQ-016 SHALL time each state with a ms counter cleared on state entry; a state lasts exactly its *_MS x CLK_HZ/1000 cycles.
REQ-017 SHALL go IDLE->BEEP on the cycle after start=1 with beep index=0.
REQ-018 SHALL go BEEP->GAP on BEEP_MS expiry when index<BEEP_COUNT-1, else to end-of-group.
REQ-019 SHALL go GAP->BEEP on GAP_MS expiry, incrementing beep index.
REQ-020 SHALL toggle buzzer every CLK_HZ/(2*TONE_HZ) cycles while in BEEP, starting high on the first BEEP cycle; tone divider restarts on each BEEP entry.
REQ-021 SHALL force buzzer=0 in all states other than BEEP, including the cycle of leaving BEEP.
REQ-022 SHALL ignore start while active=1 (no restart of pattern).
REQ-023 SHALL go to IDLE on the cycle after stop=1 from any state; stop wins over simultaneous start.
REQ-024 SHALL size all counters with $clog2 of their maximum count; no counter may wrap before its terminal value.

Reset
REQ-025 SHALL on reset_n=0 asynchronously force state IDLE, all counters 0, buzzer=0, beep_on=0, active=0.
REQ-026 SHALL, after reset release mid-pattern, remain IDLE until a new start.

Configuration
REQ-027 SHALL use macro ALARM_REPEAT_EN: defined -> end-of-group goes BEEP->PAUSE, PAUSE->BEEP (index=0) after REPEAT_MS, repeating until stop.
REQ-028 SHALL without ALARM_REPEAT_EN make end-of-group go BEEP->IDLE and exclude PAUSE logic and REPEAT_MS counter.

Structure
REQ-029 SHALL place the state enum type and the ms-per-second constant (1000) in shared package alarm_pkg.
REQ-030 SHALL implement the tone divider as sub-module tone_gen (inputs clk, reset_n, enable; output square wave).

Verification (params CLK_HZ=10_000, TONE_HZ=1000, BEEP_MS=2, GAP_MS=1, BEEP_COUNT=2, REPEAT_MS=3)
REQ-031 SHALL cover: start pulse, macro off -> beep_on high 20 cycles, low 10, high 20, then active=0; buzzer toggles every 5 cycles only while beep_on.
REQ-032 SHALL cover: macro on, start -> after second beep, 30 silent cycles then beep_on rises again; pattern repeats 3 groups until stop.
REQ-033 SHALL cover: stop during BEEP at cycle 7 -> buzzer=0, beep_on=0, active=0 next cycle.
REQ-034 SHALL cover: start and stop asserted same cycle while IDLE -> active stays 0.
REQ-035 SHALL cover: start during GAP -> pattern timing unchanged versus no-start run.
REQ-036 SHALL cover: reset_n low mid-BEEP between clock edges -> all outputs 0 immediately, IDLE held after release until start.
